// File: rtl/dmem_responder.sv
// Data-memory responder: LW/LBU/SW/SB against a word-organised synchronous-read RAM,
// SB as read-modify-write. Optional misaligned-word check enabled by DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic              req_byte_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              busy_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam int DEPTH = 1 << ADDR_WORDS_LOG2;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid and
  // payload stay stable until that edge, and ready never depends on valid.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_MERGE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]          mem [DEPTH];
  logic [DATA_W-1:0]          rd_data_q;
  logic [DATA_W-1:0]          wdata_q;
  logic [ADDR_WORDS_LOG2-1:0] idx_q;
  logic [1:0]                 lane_q;
  logic                       we_q;
  logic                       byte_q;
  logic                       mis_q;
  logic                       mis_now;
  logic                       accept;
  logic                       wr_en;
  logic [DATA_W-1:0]          wr_data;
  logic [DATA_W-1:0]          merged;
  logic [7:0]                 lane_byte;
  logic                       unused_addr;

  assign unused_addr = ^req_addr_i[31:ADDR_WORDS_LOG2+2];

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign accept       = req_valid_i && req_ready_o;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_now = !req_byte_i && (req_addr_i[1:0] != 2'b00);

  // One-cycle pulse in the cycle after a misaligned word op is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= accept && mis_now;
    end
  end
`else
  assign mis_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (req_we_i && !req_byte_i) ? S_WR : S_RD;
      S_WR:    state_d = S_IDLE;
      S_RD:    state_d = we_q ? S_MERGE : S_RESP;
      S_MERGE: state_d = S_IDLE;
      S_RESP:  if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      lane_q  <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we_i;
      byte_q  <= req_byte_i;
      lane_q  <= req_addr_i[1:0];
      idx_q   <= req_addr_i[ADDR_WORDS_LOG2+1:2];
      wdata_q <= req_wdata_i;
      mis_q   <= mis_now;
    end
  end

  // Read-data register only loads in RD so the response stays stable under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (state_q == S_RD) begin
      rd_data_q <= mem[idx_q];
    end
  end

  always_comb begin
    lane_byte = rd_data_q[7:0];
    case (lane_q)
      2'd0: lane_byte = rd_data_q[7:0];
      2'd1: lane_byte = rd_data_q[15:8];
      2'd2: lane_byte = rd_data_q[23:16];
      2'd3: lane_byte = rd_data_q[31:24];
      default: lane_byte = rd_data_q[7:0];
    endcase
  end

  always_comb begin
    merged = rd_data_q;
    case (lane_q)
      2'd0: merged[7:0]   = wdata_q[7:0];
      2'd1: merged[15:8]  = wdata_q[7:0];
      2'd2: merged[23:16] = wdata_q[7:0];
      2'd3: merged[31:24] = wdata_q[7:0];
      default: merged = rd_data_q;
    endcase
  end

  // Write only happens from WR/MERGE, so a reset during an SB drops the merge.
  assign wr_en   = ((state_q == S_WR) && !mis_q) || (state_q == S_MERGE);
  assign wr_data = (state_q == S_MERGE) ? merged : wdata_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx_q] <= wr_data;
    end
  end

  always_comb begin
    resp_data_o = '0;
    if ((state_q == S_RESP) && !mis_q) begin
      resp_data_o = byte_q ? {{(DATA_W-8){1'b0}}, lane_byte} : rd_data_q;
    end
  end

endmodule
